// File: rtl/layer_mixer_pkg.sv
// rtl/layer_mixer_pkg.sv - shared widths, RGB332 fields and collision pair indexing
package layer_mixer_pkg;

  localparam int COLOR_W_DEF = 8;

  localparam int RGB332_R_LSB = 5;
  localparam int RGB332_R_W   = 3;
  localparam int RGB332_G_LSB = 2;
  localparam int RGB332_G_W   = 3;
  localparam int RGB332_B_LSB = 0;
  localparam int RGB332_B_W   = 2;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Bit position of unordered pair (i, j), i < j, in a coll_flags vector for n layers.
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/layer_coll_accum.sv
// rtl/layer_coll_accum.sv - sticky per-frame layer overlap accumulator, published at vblank rise
module layer_coll_accum
  import layer_mixer_pkg::*;
#(
  parameter int  NUM_LAYERS = 4,
  localparam int NUM_PAIRS  = num_pairs(NUM_LAYERS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pix_en,
  input  logic [NUM_LAYERS-1:0] i_eff,
  input  logic                  i_blank,
  input  logic                  i_vblank,
  output logic [NUM_PAIRS-1:0]  o_coll_flags,
  output logic                  o_coll_strobe
);

  logic [NUM_PAIRS-1:0] r_acc;
  logic [NUM_PAIRS-1:0] r_flags;
  logic [NUM_PAIRS-1:0] w_hits;
  logic                 r_strobe;
  logic                 r_vblank_prev;
  logic                 r_primed;
  logic                 w_frame_edge;

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      for (int j = i + 1; j < NUM_LAYERS; j++) begin
        if (i_eff[i] && i_eff[j]) begin
          w_hits = w_hits | (NUM_PAIRS'(1) << pair_index(i, j, NUM_LAYERS));
        end
      end
    end
  end

  assign w_frame_edge = i_vblank & ~r_vblank_prev;

  // The stage-1 vblank register holds its reset value (0) on the first pix_en,
  // so the previous-vblank register keeps its reset 1 until real data arrives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc         <= '0;
      r_flags       <= '0;
      r_strobe      <= 1'b0;
      r_vblank_prev <= 1'b1;
      r_primed      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (i_pix_en) begin
        r_primed      <= 1'b1;
        r_vblank_prev <= i_vblank | ~r_primed;
        if (w_frame_edge) begin
          r_flags  <= r_acc;
          r_acc    <= '0;
          r_strobe <= 1'b1;
        end else if (!i_blank) begin
          r_acc <= r_acc | w_hits;
        end
      end
    end
  end

  assign o_coll_flags  = r_flags;
  assign o_coll_strobe = r_strobe;

endmodule

// File: rtl/layer_mixer.sv
// rtl/layer_mixer.sv - fixed-priority layer compositor with blanking and per-frame collision flags
module layer_mixer
  import layer_mixer_pkg::*;
#(
  parameter int  NUM_LAYERS = 4,
  parameter int  COLOR_W    = COLOR_W_DEF,
  localparam int NUM_PAIRS  = num_pairs(NUM_LAYERS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_pix_en,
  input  logic                          i_blank,
  input  logic                          i_vblank,
  input  logic [NUM_LAYERS-1:0]         i_layer_valid,
  input  logic [NUM_LAYERS*COLOR_W-1:0] i_layer_color,
  input  logic [NUM_LAYERS-1:0]         i_layer_en,
  input  logic [COLOR_W-1:0]            i_bg_color,
  output logic [COLOR_W-1:0]            o_rgb,
  output logic [NUM_PAIRS-1:0]          o_coll_flags,
  output logic                          o_coll_strobe
);

  logic [NUM_LAYERS-1:0]         r_eff;
  logic [NUM_LAYERS*COLOR_W-1:0] r_color;
  logic [COLOR_W-1:0]            r_bg;
  logic                          r_blank;
  logic                          r_vblank;
  logic [COLOR_W-1:0]            r_rgb;
  logic [COLOR_W-1:0]            w_pix;

  // Walk from lowest priority upward so the lowest-index hit wins.
  always_comb begin
    w_pix = r_bg;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_eff[i]) begin
        w_pix = r_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_eff    <= '0;
      r_color  <= '0;
      r_bg     <= '0;
      r_blank  <= 1'b0;
      r_vblank <= 1'b0;
      r_rgb    <= '0;
    end else if (i_pix_en) begin
      r_eff    <= i_layer_valid & i_layer_en;
      r_color  <= i_layer_color;
      r_bg     <= i_bg_color;
      r_blank  <= i_blank;
      r_vblank <= i_vblank;
      r_rgb    <= r_blank ? '0 : w_pix;
    end
  end

  assign o_rgb = r_rgb;

  layer_coll_accum #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_coll (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pix_en      (i_pix_en),
    .i_eff         (r_eff),
    .i_blank       (r_blank),
    .i_vblank      (r_vblank),
    .o_coll_flags  (o_coll_flags),
    .o_coll_strobe (o_coll_strobe)
  );

endmodule
